huc_rtc_core: RTL and testbench

HUC_RTC_CORE -- requirements
Module: huc_rtc_core

---
 rtl/huc_rtc_pkg.sv | 34 +++
 rtl/huc_rtc_counter.sv | 78 +++++++
 rtl/huc_rtc_core.sv | 199 +++++++++++++++++++
 tb/tb_huc_rtc_core.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/huc_rtc_pkg.sv
// HuC3-style RTC shared definitions: command opcodes, nibble register map
// and the widths/limits of the seconds/minutes/days time chain.
package huc_rtc_pkg;

    localparam int unsigned SEC_W = 6;
    localparam int unsigned MIN_W = 12;
    localparam int unsigned DAY_W = 16;

    localparam logic [SEC_W-1:0] SEC_LAST = 6'd59;
    localparam logic [MIN_W-1:0] MIN_LAST = 12'd1439;

    typedef enum logic [3:0] {
        OP_NOP       = 4'h0,
        OP_READ      = 4'h1,
        OP_WRITE     = 4'h2,
        OP_WRITE_INC = 4'h3,
        OP_IDX_LO    = 4'h4,
        OP_IDX_HI    = 4'h5,
        OP_FLAGS     = 4'h6,
        OP_ALM_CLR   = 4'h7
    } huc_op_e;

    localparam logic [7:0] REG_MIN0 = 8'd0;
    localparam logic [7:0] REG_MIN1 = 8'd1;
    localparam logic [7:0] REG_MIN2 = 8'd2;
    localparam logic [7:0] REG_DAY0 = 8'd3;
    localparam logic [7:0] REG_DAY1 = 8'd4;
    localparam logic [7:0] REG_DAY2 = 8'd5;
    localparam logic [7:0] REG_DAY3 = 8'd6;
    localparam logic [7:0] REG_ALM0 = 8'd7;
    localparam logic [7:0] REG_ALM1 = 8'd8;
    localparam logic [7:0] REG_ALM2 = 8'd9;

endpackage

// File: rtl/huc_rtc_counter.sv
// Seconds/minutes/days chain.
//   advance          : step one second
//   load, load_*     : bulk load of all three fields (save-state restore)
//   sec_clr, *_wr    : CPU field writes, highest priority per field
//   sec/min/day      : live counter values
//   min_roll/min_adv : seconds wrapped this cycle, and the minute it moves to
module huc_rtc_counter
    import huc_rtc_pkg::*;
(
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             advance,
    input  logic             load,
    input  logic [SEC_W-1:0] load_sec,
    input  logic [MIN_W-1:0] load_min,
    input  logic [DAY_W-1:0] load_day,
    input  logic             sec_clr,
    input  logic             min_wr,
    input  logic [MIN_W-1:0] min_wdata,
    input  logic             day_wr,
    input  logic [DAY_W-1:0] day_wdata,
    output logic [SEC_W-1:0] sec,
    output logic [MIN_W-1:0] min,
    output logic [DAY_W-1:0] day,
    output logic             min_roll,
    output logic [MIN_W-1:0] min_adv
);

    logic [SEC_W-1:0] sec_q, sec_d;
    logic [MIN_W-1:0] min_q, min_d;
    logic [DAY_W-1:0] day_q, day_d;

    always_comb begin
        // >= so that an out-of-range CPU-written value still wraps
        min_adv  = (min_q >= MIN_LAST) ? '0 : min_q + 1'b1;
        min_roll = advance && (sec_q >= SEC_LAST);

        sec_d = sec_q;
        min_d = min_q;
        day_d = day_q;
        if (advance) begin
            if (sec_q >= SEC_LAST) begin
                sec_d = '0;
                min_d = min_adv;
                if (min_q >= MIN_LAST) begin
                    day_d = day_q + 1'b1;
                end
            end else begin
                sec_d = sec_q + 1'b1;
            end
        end
        if (load) begin
            sec_d = load_sec;
            min_d = load_min;
            day_d = load_day;
        end
        if (sec_clr) sec_d = '0;
        if (min_wr)  min_d = min_wdata;
        if (day_wr)  day_d = day_wdata;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            sec_q <= '0;
            min_q <= '0;
            day_q <= '0;
        end else begin
            sec_q <= sec_d;
            min_q <= min_d;
            day_q <= day_d;
        end
    end

    assign sec = sec_q;
    assign min = min_q;
    assign day = day_q;

endmodule

// File: rtl/huc_rtc_core.sv
// HuC3-style real-time clock core.
//   clk_sys/reset        : system clock, async active-high reset
//   ce_cpu/cmd_wr/cmd_di : CPU command port ([7:4] opcode, [3:0] operand)
//   rtc_out/rtc_flags    : last read nibble, flags register
//   busy/alarm           : catch-up in progress, alarm latched
//   RTC_time             : host epoch seconds, bit 32 toggles on update
//   save_load/save_ts/save_time : save-state restore
//   ts_out/time_out      : running epoch, registered time {14'b0,day,min,sec}
module huc_rtc_core
    import huc_rtc_pkg::*;
#(
    parameter int unsigned PRESCALE    = 33554432,
    parameter int unsigned NREG        = 10,
    parameter int unsigned ALARM_EN    = 1,
    parameter logic [31:0] CATCHUP_MAX = 32'hFFFFFFFF
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ce_cpu,
    input  logic        cmd_wr,
    input  logic [7:0]  cmd_di,
    output logic [3:0]  rtc_out,
    output logic [3:0]  rtc_flags,
    output logic        busy,
    output logic        alarm,
    input  logic [32:0] RTC_time,
    input  logic        save_load,
    input  logic [31:0] save_ts,
    input  logic [47:0] save_time,
    output logic [31:0] ts_out,
    output logic [47:0] time_out
);

    localparam logic [31:0] PRESC_LAST = 32'(PRESCALE - 1);
    localparam logic [31:0] NREG_L     = 32'(NREG);

    logic [31:0]      presc_q, presc_d, ts_q, ts_d, catch_q, catch_d, diff;
    logic [7:0]       idx_q, idx_d;
    logic [3:0]       flags_q, flags_d, rtc_out_q, rtc_out_d, nib, rd_nib;
    logic [MIN_W-1:0] alm_q, alm_d;
    logic             alarm_q, alarm_d, rtc_tgl_q, rtc_tgl_d;
    logic [47:0]      time_q, time_d;

    logic             cmd_en, idx_ok, is_wr, wr_idx0, tick, advance;
    huc_op_e          op;
    logic             sec_clr, min_wr, day_wr, min_roll;
    logic [SEC_W-1:0] cnt_sec;
    logic [MIN_W-1:0] cnt_min, min_wdata, min_adv;
    logic [DAY_W-1:0] cnt_day, day_wdata;
    logic             unused_pad;

    huc_rtc_counter u_counter (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .advance   (advance),
        .load      (save_load),
        .load_sec  (save_time[5:0]),
        .load_min  (save_time[17:6]),
        .load_day  (save_time[33:18]),
        .sec_clr   (sec_clr),
        .min_wr    (min_wr),
        .min_wdata (min_wdata),
        .day_wr    (day_wr),
        .day_wdata (day_wdata),
        .sec       (cnt_sec),
        .min       (cnt_min),
        .day       (cnt_day),
        .min_roll  (min_roll),
        .min_adv   (min_adv)
    );

    always_comb begin
        unused_pad = ^save_time[47:34];
        cmd_en     = ce_cpu & cmd_wr;
        op         = huc_op_e'(cmd_di[7:4]);
        nib        = cmd_di[3:0];
        idx_ok     = {24'b0, idx_q} < NREG_L;
        is_wr      = cmd_en && ((op == OP_WRITE) || (op == OP_WRITE_INC)) && idx_ok;
        wr_idx0    = is_wr && (idx_q == REG_MIN0);
    end

    always_comb begin
        rd_nib = '0;
        if (idx_ok) begin
            case (idx_q)
                REG_MIN0: rd_nib = cnt_min[3:0];
                REG_MIN1: rd_nib = cnt_min[7:4];
                REG_MIN2: rd_nib = cnt_min[11:8];
                REG_DAY0: rd_nib = cnt_day[3:0];
                REG_DAY1: rd_nib = cnt_day[7:4];
                REG_DAY2: rd_nib = cnt_day[11:8];
                REG_DAY3: rd_nib = cnt_day[15:12];
                REG_ALM0: if (ALARM_EN != 0) rd_nib = alm_q[3:0];
                REG_ALM1: if (ALARM_EN != 0) rd_nib = alm_q[7:4];
                REG_ALM2: if (ALARM_EN != 0) rd_nib = alm_q[11:8];
                default:  rd_nib = '0;
            endcase
        end
    end

    // Nibble writes patch the live field value; the counter gives them
    // priority over advance/load for the field written.
    always_comb begin
        sec_clr   = 1'b0;
        min_wr    = 1'b0;
        min_wdata = cnt_min;
        day_wr    = 1'b0;
        day_wdata = cnt_day;
        alm_d     = alm_q;
        if (is_wr) begin
            case (idx_q)
                REG_MIN0: begin min_wr = 1'b1; min_wdata[3:0] = nib; sec_clr = 1'b1; end
                REG_MIN1: begin min_wr = 1'b1; min_wdata[7:4]  = nib; end
                REG_MIN2: begin min_wr = 1'b1; min_wdata[11:8] = nib; end
                REG_DAY0: begin day_wr = 1'b1; day_wdata[3:0]   = nib; end
                REG_DAY1: begin day_wr = 1'b1; day_wdata[7:4]   = nib; end
                REG_DAY2: begin day_wr = 1'b1; day_wdata[11:8]  = nib; end
                REG_DAY3: begin day_wr = 1'b1; day_wdata[15:12] = nib; end
                REG_ALM0: if (ALARM_EN != 0) alm_d[3:0]  = nib;
                REG_ALM1: if (ALARM_EN != 0) alm_d[7:4]  = nib;
                REG_ALM2: if (ALARM_EN != 0) alm_d[11:8] = nib;
                default: ;
            endcase
        end
    end

    always_comb begin
        // A write to minutes nibble 0 restarts the second: no tick that cycle
        tick    = (presc_q == PRESC_LAST) && !wr_idx0;
        presc_d = (presc_q == PRESC_LAST || wr_idx0) ? '0 : presc_q + 1'b1;
        advance = tick || (catch_q != '0);

        diff    = ts_q - save_ts;
        catch_d = catch_q;
        if (save_load) begin
            if (ts_q > save_ts) catch_d = (diff > CATCHUP_MAX) ? CATCHUP_MAX : diff;
            else                catch_d = '0;
        end else if ((catch_q != '0) && !tick) begin
            catch_d = catch_q - 1'b1;
        end

        rtc_tgl_d = RTC_time[32];
        ts_d      = tick ? ts_q + 1'b1 : ts_q;
        if (RTC_time[32] != rtc_tgl_q) ts_d = RTC_time[31:0];

        time_d = {14'b0, cnt_day, cnt_min, cnt_sec};

        idx_d     = idx_q;
        flags_d   = flags_q;
        rtc_out_d = rtc_out_q;
        alarm_d   = alarm_q;
        if ((ALARM_EN != 0) && flags_q[3] && min_roll && (min_adv == alm_q)) alarm_d = 1'b1;
        if (cmd_en) begin
            case (op)
                OP_READ:      begin rtc_out_d = rd_nib; idx_d = idx_q + 1'b1; end
                OP_WRITE_INC: idx_d = idx_q + 1'b1;
                OP_IDX_LO:    idx_d[3:0] = nib;
                OP_IDX_HI:    idx_d[7:4] = nib;
                OP_FLAGS:     flags_d = nib;
                OP_ALM_CLR:   alarm_d = 1'b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            presc_q   <= '0;
            ts_q      <= '0;
            catch_q   <= '0;
            idx_q     <= '0;
            flags_q   <= '0;
            rtc_out_q <= '0;
            alm_q     <= '0;
            alarm_q   <= 1'b0;
            rtc_tgl_q <= 1'b0;
            time_q    <= '0;
        end else begin
            presc_q   <= presc_d;
            ts_q      <= ts_d;
            catch_q   <= catch_d;
            idx_q     <= idx_d;
            flags_q   <= flags_d;
            rtc_out_q <= rtc_out_d;
            alm_q     <= alm_d;
            alarm_q   <= alarm_d;
            rtc_tgl_q <= rtc_tgl_d;
            time_q    <= time_d;
        end
    end

    assign rtc_out   = rtc_out_q;
    assign rtc_flags = flags_q;
    assign busy      = (catch_q != '0);
    assign alarm     = alarm_q;
    assign ts_out    = ts_q;
    assign time_out  = time_q;

endmodule

// File: tb/tb_huc_rtc_core.sv
module tb_huc_rtc_core;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        ce_cpu = 1'b0;
    logic        cmd_wr = 1'b0;
    logic [7:0]  cmd_di = '0;
    logic [32:0] RTC_time = '0;
    logic        save_load = 1'b0;
    logic [31:0] save_ts = '0;
    logic [47:0] save_time = '0;

    logic [3:0]  rtc_out_a, rtc_flags_a, rtc_out_b, rtc_flags_b;
    logic        busy_a, alarm_a, busy_b, alarm_b;
    logic [31:0] ts_out_a, ts_out_b;
    logic [47:0] time_out_a, time_out_b;

    // dut_a ticks every 4 cycles; dut_b effectively never ticks in this run
    huc_rtc_core #(.PRESCALE(4)) dut_a (
        .clk_sys(clk_sys), .reset(reset), .ce_cpu(ce_cpu), .cmd_wr(cmd_wr),
        .cmd_di(cmd_di), .rtc_out(rtc_out_a), .rtc_flags(rtc_flags_a),
        .busy(busy_a), .alarm(alarm_a), .RTC_time(RTC_time),
        .save_load(save_load), .save_ts(save_ts), .save_time(save_time),
        .ts_out(ts_out_a), .time_out(time_out_a)
    );

    huc_rtc_core #(.PRESCALE(1000000)) dut_b (
        .clk_sys(clk_sys), .reset(reset), .ce_cpu(ce_cpu), .cmd_wr(cmd_wr),
        .cmd_di(cmd_di), .rtc_out(rtc_out_b), .rtc_flags(rtc_flags_b),
        .busy(busy_b), .alarm(alarm_b), .RTC_time(RTC_time),
        .save_load(save_load), .save_ts(save_ts), .save_time(save_time),
        .ts_out(ts_out_b), .time_out(time_out_b)
    );

    always #5 clk_sys = ~clk_sys;

    localparam int B_RTC = 0, B_FLG = 1, B_BSY = 2, B_ALM = 3, B_TS = 4, B_TIM = 5;
    localparam int A_BSY = 12, A_TS = 14, A_TIM = 15;

    typedef struct {
        int unsigned due;
        int          sel;
        logic [47:0] exp;
        string       name;
    } chk_t;

    chk_t        sbq[$];
    int unsigned cyc = 0;
    int          total = 0;
    int          bad = 0;
    int unsigned last_clr = 0;

    always @(posedge clk_sys) cyc <= cyc + 1;

    function automatic logic [47:0] actual(input int sel);
        case (sel)
            B_RTC:   return {44'b0, rtc_out_b};
            B_FLG:   return {44'b0, rtc_flags_b};
            B_BSY:   return {47'b0, busy_b};
            B_ALM:   return {47'b0, alarm_b};
            B_TS:    return {16'b0, ts_out_b};
            B_TIM:   return time_out_b;
            A_BSY:   return {47'b0, busy_a};
            A_TS:    return {16'b0, ts_out_a};
            A_TIM:   return time_out_a;
            default: return 48'hDEAD;
        endcase
    endfunction

    function automatic logic [47:0] pk(input logic [15:0] d, input logic [11:0] m,
                                       input logic [5:0] s);
        return {14'b0, d, m, s};
    endfunction

    // Monitor: compares every expectation whose due cycle has arrived
    always @(negedge clk_sys) begin : monitor
        logic [47:0] got;
        for (int i = int'(sbq.size()) - 1; i >= 0; i--) begin
            if (sbq[i].due == cyc) begin
                got = actual(sbq[i].sel);
                total++;
                if (got !== sbq[i].exp) begin
                    bad++;
                    $display("FAIL %s: got=%0h want=%0h", sbq[i].name, got, sbq[i].exp);
                end
                sbq.delete(i);
            end
        end
    end

    task automatic push_chk(input int unsigned d, input int sel, input logic [47:0] v,
                            input string nm);
        chk_t c;
        c.due = cyc + d; c.sel = sel; c.exp = v; c.name = nm;
        sbq.push_back(c);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic cmd(input logic [7:0] b);
        ce_cpu = 1'b1; cmd_wr = 1'b1; cmd_di = b;
        step(1);
        cmd_wr = 1'b0; cmd_di = '0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        step(2);
        push_chk(1, B_RTC, 0, "rst_rtc_out");
        push_chk(1, B_FLG, 0, "rst_flags");
        push_chk(1, B_BSY, 0, "rst_busy");
        push_chk(1, B_ALM, 0, "rst_alarm");
        push_chk(1, B_TS,  0, "rst_ts");
        push_chk(1, B_TIM, 0, "rst_time");
        push_chk(1, A_TS,  0, "rst_ts_a");
        step(1);
        reset = 1'b0;
        ce_cpu = 1'b1;

        // Full rollover: 59s / 1439min / day 65535 -> all zero on first tick
        save_load = 1'b1; save_ts = 32'hFFFFFFFF; save_time = pk(16'hFFFF, 12'd1439, 6'd59);
        push_chk(1, A_BSY, 0, "wrap_no_catchup");
        push_chk(3, A_TS,  0, "wrap_ts_before_tick");
        push_chk(4, A_TIM, pk(16'hFFFF, 12'd1439, 6'd59), "wrap_time_loaded");
        push_chk(4, A_TS,  1, "wrap_ts_after_tick");
        push_chk(5, A_TIM, 0, "wrap_time_zero");
        push_chk(5, B_TIM, pk(16'hFFFF, 12'd1439, 6'd59), "no_tick_time_b");
        step(1);
        save_load = 1'b0;
        step(6);

        // Catch-up: ts 1000, saved 900 -> 100 advances
        RTC_time = {1'b1, 32'd1000};
        push_chk(1, B_TS, 1000, "rtc_load_ts");
        step(1);
        save_load = 1'b1; save_ts = 32'd900; save_time = pk(16'd5, 12'd10, 6'd0);
        push_chk(1,   B_BSY, 1, "catchup_busy_start");
        push_chk(100, B_BSY, 1, "catchup_busy_last");
        push_chk(101, B_BSY, 0, "catchup_done");
        push_chk(102, B_TIM, pk(16'd5, 12'd11, 6'd40), "catchup_time");
        push_chk(102, B_TS,  1000, "catchup_ts_kept");
        step(1);
        save_load = 1'b0;
        step(110);

        // Nibble writes then reads back of minutes
        cmd(8'h40); cmd(8'h50);
        last_clr = cyc;
        cmd(8'h37); cmd(8'h33); cmd(8'h31);
        cmd(8'h40);
        push_chk(1, B_RTC, 7, "read_min0"); cmd(8'h10);
        push_chk(1, B_RTC, 3, "read_min1"); cmd(8'h10);
        push_chk(1, B_RTC, 1, "read_min2"); cmd(8'h10);
        push_chk(2, B_TIM, pk(16'd5, 12'h137, 6'd0), "minutes_137");
        step(3);

        // Alarm at minute 5 via one catch-up second from 4:59
        cmd(8'h47); cmd(8'h50); cmd(8'h35); cmd(8'h30); cmd(8'h30);
        push_chk(1, B_FLG, 8, "flags_8"); cmd(8'h68);
        save_load = 1'b1; save_ts = 32'd999; save_time = pk(16'd5, 12'd4, 6'd59);
        push_chk(1, B_ALM, 0, "alarm_before_roll");
        push_chk(2, B_ALM, 1, "alarm_set");
        push_chk(5, B_ALM, 1, "alarm_held");
        step(1);
        save_load = 1'b0;
        step(5);
        push_chk(1, B_ALM, 0, "alarm_clear"); cmd(8'h70);
        step(1);

        // Out-of-range index, alarm register read, gating, no-op opcode
        cmd(8'h4C); cmd(8'h50); cmd(8'h2F);
        push_chk(1, B_RTC, 0, "read_oor"); cmd(8'h10);
        cmd(8'h47); cmd(8'h50);
        push_chk(1, B_RTC, 5, "read_alarm0"); cmd(8'h10);
        ce_cpu = 1'b0; cmd_wr = 1'b1; cmd_di = 8'h6F;
        push_chk(1, B_FLG, 8, "ce_gated");
        step(1);
        ce_cpu = 1'b1; cmd_wr = 1'b0;
        push_chk(1, B_RTC, 5, "nop_rtc"); push_chk(1, B_FLG, 8, "nop_flags"); cmd(8'h80);

        // RTC_time toggle landing on a dut_a tick cycle
        for (int k = 0; k < 8 && ((cyc - last_clr) % 4) != 0; k++) step(1);
        RTC_time = {1'b0, 32'h12345678};
        push_chk(1, A_TS, 32'h12345678, "toggle_overrides_tick");
        push_chk(1, B_TS, 32'h12345678, "toggle_load_b");
        push_chk(4, A_TS, 32'h12345678, "toggle_hold");
        push_chk(5, A_TS, 32'h12345679, "tick_after_toggle");
        step(6);

        // Reset during a long catch-up
        save_load = 1'b1; save_ts = 32'd0; save_time = '0;
        push_chk(1, B_BSY, 1, "long_catchup_busy");
        step(1);
        save_load = 1'b0;
        step(2);
        push_chk(1, B_BSY, 0, "reset_abort_busy");
        push_chk(1, A_BSY, 0, "reset_abort_busy_a");
        push_chk(1, B_TS,  0, "reset_ts");
        push_chk(1, B_FLG, 0, "reset_flags");
        push_chk(1, B_RTC, 0, "reset_rtc_out");
        push_chk(1, B_TIM, 0, "reset_time");
        #2;
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(2);

        if (sbq.size() != 0) begin
            $display("FAIL scoreboard_drain: got=%0d pending want=0", sbq.size());
            bad += int'(sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
